// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchroniser, 16x oversampling from a baud-tick
// divider, one-entry holding register with valid/read handshake, framing and overrun pulses.
module uart_rx #(
    parameter int BAUD_DIV   = 27,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iRX_DATA,
    input  logic       iREAD,
    output logic [7:0] oRX_DATA,
    output logic       oRX_VALID,
    output logic       oFRAME_ERR,
    output logic       oOVERRUN,
    output logic       oBUSY
);

    localparam logic [15:0] DIV_LAST  = 16'(BAUD_DIV - 1);
    localparam logic [3:0]  TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0]  TICK_MID  = 4'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t      state;
    logic        rx_meta;
    logic        rx_s;
    logic [15:0] div_cnt;
    logic        tick;
    logic [3:0]  tick_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;

    // Synchroniser resets to the idle (high) line level so reset never looks like a start bit.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= iRX_DATA;
            rx_s    <= rx_meta;
        end
    end

    assign tick = (state != IDLE) && (div_cnt == DIV_LAST);

    // Held at zero in IDLE, so the first tick lands BAUD_DIV clks after start detect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            div_cnt <= '0;
        else if (state == IDLE || tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            oRX_DATA   <= '0;
            oRX_VALID  <= 1'b0;
            oFRAME_ERR <= 1'b0;
            oOVERRUN   <= 1'b0;
        end else begin
            oFRAME_ERR <= 1'b0;
            oOVERRUN   <= 1'b0;
            if (iREAD)
                oRX_VALID <= 1'b0;
            if (tick)
                tick_cnt <= tick_cnt + 4'd1;

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        tick_cnt <= '0;
                    end
                end
                START: begin
                    if (tick && tick_cnt == TICK_MID) begin
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            state    <= DATA;
                            tick_cnt <= '0;
                            bit_idx  <= '0;
                        end
                    end
                end
                DATA: begin
                    if (tick && tick_cnt == TICK_LAST) begin
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            state <= STOP;
                    end
                end
                STOP: begin
                    // Leaving at mid stop bit lets a back-to-back start edge be caught.
                    if (tick && tick_cnt == TICK_LAST) begin
                        if (rx_s) begin
                            oRX_DATA  <= shreg;
                            oRX_VALID <= 1'b1;
                            oOVERRUN  <= oRX_VALID && !iREAD;
                            state     <= IDLE;
                        end else begin
                            oFRAME_ERR <= 1'b1;
                            state      <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rx_s)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign oBUSY = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at BAUD_DIV=4 (64 clk per bit): single byte, back-to-back,
// glitch, framing/break, overrun, reset mid-frame and +/-3% baud skew.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int BIT = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       iRX_DATA;
    logic       iREAD;
    logic [7:0] oRX_DATA;
    logic       oRX_VALID;
    logic       oFRAME_ERR;
    logic       oOVERRUN;
    logic       oBUSY;

    int n_vec = 0;
    int n_err = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int vr_cnt = 0;
    logic valid_d = 1'b0;

    uart_rx #(.BAUD_DIV(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .iRX_DATA  (iRX_DATA),
        .iREAD     (iREAD),
        .oRX_DATA  (oRX_DATA),
        .oRX_VALID (oRX_VALID),
        .oFRAME_ERR(oFRAME_ERR),
        .oOVERRUN  (oOVERRUN),
        .oBUSY     (oBUSY)
    );

    always #5 clk = ~clk;

    // Pulse and event counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (oFRAME_ERR) fe_cnt++;
        if (oOVERRUN) ov_cnt++;
        if (oRX_VALID && !valid_d) vr_cnt++;
        valid_d = oRX_VALID;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Start, 8 data bits LSB first, stop; line is left at the stop level.
    task automatic send_byte(input logic [7:0] d, input logic stop, input int per);
        @(posedge clk); #1 iRX_DATA = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (per) @(posedge clk);
            #1 iRX_DATA = d[i];
        end
        repeat (per) @(posedge clk);
        #1 iRX_DATA = stop;
        repeat (per - 1) @(posedge clk);
        #1;
    endtask

    task automatic read_pulse();
        iREAD = 1'b1;
        @(posedge clk); #1 iREAD = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output logic ok);
        int c = 0;
        while (!oRX_VALID && c < limit) begin
            @(negedge clk);
            c++;
        end
        ok = oRX_VALID;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fe0, ov0, vr0;
        logic ok;
        logic [7:0] exp_b2b [3];
        exp_b2b[0] = 8'h00; exp_b2b[1] = 8'hFF; exp_b2b[2] = 8'h55;

        reset = 1'b1; iRX_DATA = 1'b1; iREAD = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_data", oRX_DATA, 8'h00);
        check("rst_valid", oRX_VALID, 0);
        check("rst_fe", oFRAME_ERR, 0);
        check("rst_ov", oOVERRUN, 0);
        check("rst_busy", oBUSY, 0);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        // Single byte; valid must not be up at 9 bit-times but must be by 10.
        fe0 = fe_cnt; ov0 = ov_cnt; vr0 = vr_cnt;
        fork
            send_byte(8'hA5, 1'b1, BIT);
            begin
                repeat (9 * BIT + 1) @(posedge clk);
                #1 check("a5_early_valid", oRX_VALID, 0);
            end
        join
        check("a5_data", oRX_DATA, 8'hA5);
        check("a5_valid", oRX_VALID, 1);
        check("a5_events", vr_cnt - vr0, 1);
        check("a5_fe", fe_cnt - fe0, 0);
        check("a5_ov", ov_cnt - ov0, 0);
        read_pulse();
        check("a5_read_clears", oRX_VALID, 0);

        // Back-to-back frames, consumer reads each one.
        fe0 = fe_cnt; ov0 = ov_cnt; vr0 = vr_cnt;
        fork
            begin
                send_byte(8'h00, 1'b1, BIT);
                send_byte(8'hFF, 1'b1, BIT);
                send_byte(8'h55, 1'b1, BIT);
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    wait_valid(1000, ok);
                    check("b2b_valid_seen", ok, 1);
                    check("b2b_data", oRX_DATA, exp_b2b[k]);
                    read_pulse();
                end
            end
        join
        check("b2b_events", vr_cnt - vr0, 3);
        check("b2b_fe", fe_cnt - fe0, 0);
        check("b2b_ov", ov_cnt - ov0, 0);
        check("b2b_valid_after", oRX_VALID, 0);

        // 20-clk glitch on idle line.
        fe0 = fe_cnt; vr0 = vr_cnt;
        iRX_DATA = 1'b0;
        repeat (10) @(posedge clk);
        #1 check("glitch_busy", oBUSY, 1);
        repeat (10) @(posedge clk);
        #1 iRX_DATA = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("glitch_idle", oBUSY, 0);
        check("glitch_no_valid", vr_cnt - vr0, 0);
        check("glitch_no_fe", fe_cnt - fe0, 0);

        // Framing error, then a long break must not retrigger.
        fe0 = fe_cnt; ov0 = ov_cnt;
        send_byte(8'h3C, 1'b0, BIT);
        check("fe_pulse", fe_cnt - fe0, 1);
        check("fe_valid_kept", oRX_VALID, 0);
        check("fe_data_kept", oRX_DATA, 8'h55);
        repeat (800) @(posedge clk);
        #1;
        check("break_busy", oBUSY, 1);
        check("break_no_retrigger", fe_cnt - fe0, 1);
        iRX_DATA = 1'b1;
        repeat (10) @(posedge clk);
        #1 check("break_exit", oBUSY, 0);
        check("fe_no_ov", ov_cnt - ov0, 0);

        // Overrun: two bytes without a read.
        ov0 = ov_cnt;
        send_byte(8'h12, 1'b1, BIT);
        send_byte(8'h34, 1'b1, BIT);
        check("ovr_pulse", ov_cnt - ov0, 1);
        check("ovr_data", oRX_DATA, 8'h34);
        check("ovr_valid", oRX_VALID, 1);
        read_pulse();
        check("ovr_read_clears", oRX_VALID, 0);

        // Read on the exact completion clk: stop sample lands 611 clks after start edge.
        send_byte(8'h12, 1'b1, BIT);
        ov0 = ov_cnt;
        fork
            send_byte(8'h34, 1'b1, BIT);
            begin
                repeat (611) @(posedge clk);
                #1 iREAD = 1'b1;
                @(posedge clk);
                #1 iREAD = 1'b0;
            end
        join
        check("rdc_no_ov", ov_cnt - ov0, 0);
        check("rdc_data", oRX_DATA, 8'h34);
        check("rdc_valid", oRX_VALID, 1);

        // Reset during bit 4 of 8'hC3.
        @(posedge clk); #1 iRX_DATA = 1'b0;
        for (int i = 0; i < 5; i++) begin
            repeat (BIT) @(posedge clk);
            #1 iRX_DATA = (i < 2) ? 1'b1 : 1'b0;
        end
        repeat (20) @(posedge clk);
        #1 check("mid_busy", oBUSY, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_data", oRX_DATA, 8'h00);
        check("mid_rst_valid", oRX_VALID, 0);
        check("mid_rst_busy", oBUSY, 0);
        repeat (5) @(posedge clk);
        #1 iRX_DATA = 1'b1;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        fe0 = fe_cnt;
        send_byte(8'h81, 1'b1, BIT);
        check("post_rst_data", oRX_DATA, 8'h81);
        check("post_rst_valid", oRX_VALID, 1);
        check("post_rst_fe", fe_cnt - fe0, 0);
        read_pulse();

        // Baud skew of roughly +3% and -3%.
        fe0 = fe_cnt;
        send_byte(8'h5A, 1'b1, 66);
        check("slow_data", oRX_DATA, 8'h5A);
        check("slow_valid", oRX_VALID, 1);
        read_pulse();
        repeat (10) @(posedge clk);
        #1;
        send_byte(8'h5A, 1'b1, 62);
        check("fast_data", oRX_DATA, 8'h5A);
        check("fast_valid", oRX_VALID, 1);
        check("skew_fe", fe_cnt - fe0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
8N1 UART receiver and counterpart of the existing UART transmitter: start bit low, 8 data bits LSB first, stop bit high, idle high.
- Synchronises the serial input and oversamples it 16x from an internal baud-tick divider.
- Delivers each received byte through a one-entry holding register with a valid/read handshake toward the RX FIFO or host logic.
- Reports framing error and overrun.

Parameters:
BAUD_DIV, 27, clk cycles per oversample tick (50 MHz / (115200*16) ≈ 27); legal range 2..65535
OVERSAMPLE, 16, ticks per bit; fixed at 16, not to be overridden

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
iRX_DATA  input  1  serial line, asynchronous to clk, idle high
iREAD  input  1  consumer acknowledge; clears oRX_VALID
oRX_DATA  output  8  last received byte, held until overwritten
oRX_VALID  output  1  level: unread byte present in oRX_DATA
oFRAME_ERR  output  1  one-clk pulse: stop bit sampled low
oOVERRUN  output  1  one-clk pulse: new byte arrived while oRX_VALID=1 with no iREAD
oBUSY  output  1  high whenever FSM is not in IDLE

Behaviour:
- Clocking and reset: one clock, clk; reset asynchronous active-high.
  - Reset values: oRX_DATA=8'h00, oRX_VALID=0, oFRAME_ERR=0, oOVERRUN=0, oBUSY=0.
  - Synchroniser flops reset to 1; FSM resets to IDLE; counters reset to 0.
- Reset mid-frame aborts the frame immediately. The partial byte is discarded and nothing is flagged.
- Input sync: 2-flop synchroniser on iRX_DATA. All decisions use the synchronised value rx_s, giving 2 clk input latency.
- Tick divider: counts 0..BAUD_DIV-1 and emits a 1-clk tick at BAUD_DIV-1.
  - Held at 0 in IDLE.
  - Restarts from 0 on the clk that leaves IDLE, so the first tick is BAUD_DIV clks after start detect.
- tick_cnt (4 bit): increments on each tick and wraps 15->0.
- bit_idx (3 bit): counts data bits.
- FSM states:
  - IDLE: when rx_s=0, go to START and clear tick_cnt.
  - START: on the tick where tick_cnt=7 (mid start bit), sample rx_s.
    - rx_s=1: glitch; return to IDLE with no flags.
    - rx_s=0: go to DATA; clear tick_cnt and bit_idx.
  - DATA: on each tick where tick_cnt=15 (mid bit), shift rx_s into shreg[7], with shreg shifting right so LSB arrives first.
    - bit_idx increments.
    - After the 8th sample (bit_idx was 7), go to STOP.
  - STOP: on the tick where tick_cnt=15, sample rx_s.
    - rx_s=1: load oRX_DATA<=shreg; set oRX_VALID; go to IDLE.
    - rx_s=0: pulse oFRAME_ERR; oRX_DATA and oRX_VALID are unchanged; go to BREAK.
  - BREAK: wait until rx_s=1, then go to IDLE. This prevents a held-low line from retriggering.
- Returning to IDLE at mid stop bit allows back-to-back frames with no idle gap.
- Latency: oRX_VALID rises on the clk edge after the stop-sample tick. Measured from the iRX_DATA start falling edge, that is about 2 + 9.5 bit-times.
- Handshake:
  - iREAD while oRX_VALID=1 clears oRX_VALID on the next edge.
  - iREAD while oRX_VALID=0 is ignored.
- Overrun: a byte completes while oRX_VALID=1 and iREAD=0 in that clk.
  - oRX_DATA is overwritten with the new byte.
  - oRX_VALID stays 1.
  - oOVERRUN pulses for 1 clk.
- Simultaneous completion and iREAD in the same clk: new byte loaded, oRX_VALID stays 1, no overrun.
- Framing error and overrun cannot occur in the same clk.
- oBUSY=1 in START, DATA, STOP and BREAK.

Test Plan:
- Single byte: BAUD_DIV=4 (64 clk/bit), send 8'hA5 -> oRX_DATA=8'hA5, oRX_VALID=1 about 10 bit-times after the start edge; oFRAME_ERR and oOVERRUN stay 0. Assert iREAD for 1 clk -> oRX_VALID=0 next edge.
- Back-to-back with no idle gap: send 8'h00, 8'hFF, 8'h55, reading after each -> three valid events with correct data and no errors.
- Glitch and framing:
  - A 20-clk low pulse on idle line -> returns to IDLE, no oRX_VALID, no flags.
  - Frame 8'h3C with stop bit driven low -> one oFRAME_ERR pulse, oRX_VALID unchanged. FSM stays in BREAK (oBUSY=1) until the line goes high.
- Overrun: send 8'h12 then 8'h34 without iREAD -> oRX_DATA=8'h34, oOVERRUN one pulse, oRX_VALID=1. Repeat with iREAD on the exact completion clk -> no oOVERRUN, data 8'h34.
- Reset mid-frame: assert reset during bit 4 of 8'hC3 -> all outputs reset immediately. Release and send 8'h81 -> oRX_DATA=8'h81 cleanly.
- Baud tolerance: with the transmit bit period skewed by +/-3% against BAUD_DIV=4, 8'h5A is received correctly with no framing error.
